unary_add_drv_4: RTL
====================

UNARY_ADD_DRV_4 -- requirements
Module: unary_add_drv_4

Interface
REQ-001 SHALL provide: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: start  in  1  request a transaction; sampled only in IDLE.
REQ-004 SHALL provide: opa  in  3  operand A, unsigned digit, valid range 0..4.
REQ-005 SHALL provide: opb  in  3  operand B, unsigned digit, valid range 0..4.
REQ-006 SHALL provide: din  in  1  unary result stream from the adder's dout.
REQ-007 SHALL provide: cin  in  1  carry from the adder's C.
REQ-008 SHALL provide: A, B  out  1 each  unary operand streams to the adder.
REQ-009 SHALL provide: en  out  1  adder enable.
REQ-010 SHALL provide: read_or_write  out  1  adder phase; 0 = read (accumulate), 1 = write (drain).
REQ-011 SHALL provide: result  out  3  captured unary count, held until the next done.
REQ-012 SHALL provide: carry  out  1  captured carry, held until the next done.
REQ-013 SHALL provide: busy  out  1  high in any state other than IDLE.
REQ-014 SHALL provide: done  out  1  one-cycle pulse when result and carry are valid.
REQ-015 SHALL provide: err  out  1  self-check mismatch flag (see Configuration).

Function
REQ-016 All outputs SHALL be registered; FSM states: IDLE, SEND, SETTLE, DRAIN, DONE.
REQ-017 In IDLE, start=1 SHALL latch opa and opb, each clamped to 4 if greater than 4, and enter SEND; start while busy SHALL be ignored.
REQ-018 SEND SHALL last 4 cycles (slot k=0..3) with en=1, read_or_write=0, A=(k<opa), B=(k<opb), so ones are front-packed.
REQ-019 SETTLE SHALL last 2 cycles with en=1, read_or_write=0, A=B=0, covering the adder's 2-cycle flag-to-C latency.
REQ-020 The carry capture register SHALL clear on entering SEND and set stickily if cin=1 at any sampling edge in SEND or SETTLE.
REQ-021 DRAIN SHALL last 9 cycles (W0..W8) with en=1, read_or_write=1, A=B=0.
REQ-022 The din counter SHALL clear on entering DRAIN and increment on each edge ending W1..W8 where din=1, saturating at 7; din at the W0 edge SHALL be ignored.
REQ-023 DONE SHALL last 1 cycle: en=0, read_or_write=0, done=1, result and carry updated; next state IDLE.
REQ-024 Latency SHALL be fixed: done asserts exactly 16 cycles after the edge that samples start; back-to-back start SHALL be accepted in the cycle after DONE.
REQ-025 In IDLE en, A, B, read_or_write and done SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE and drive A, B, en, read_or_write, result, carry, busy, done and err to 0, including mid-transaction.
REQ-027 After a mid-transaction reset no partial result SHALL be reported; the next start SHALL begin a fresh transaction.

Configuration
REQ-028 With UNARY_DRV_CHECK_EN defined, at DONE err SHALL be set to 1 if carry != (opa+opb >= 5) or result != ((opa+opb) mod 8), using the clamped operands, and cleared otherwise; err SHALL hold until the next DONE.
REQ-029 Without UNARY_DRV_CHECK_EN, err SHALL be constant 0 and no check logic SHALL be present.

Verification
REQ-030 opa=2, opb=1, start pulse -> A=1,1,0,0 and B=1,0,0,0 across SEND; done at 16 cycles; result=3, carry=0, err=0.
REQ-031 opa=3, opb=2 -> carry=1, result=5, err=0.
REQ-032 opa=4, opb=4 -> carry=1, result=0 (adder 3-bit wrap), err=0; opa=7 is clamped and behaves as opa=4.
REQ-033 rst_n pulsed low during DRAIN W4 -> all outputs 0 immediately, no done; a subsequent start with 1,1 -> result=2.
REQ-034 start held high continuously through a transaction -> exactly one transaction per IDLE entry; done spaced 17 cycles apart.
REQ-035 With UNARY_DRV_CHECK_EN, force cin=0 with opa=4, opb=3 -> carry=0, err=1; without the macro -> err=0.

Source files
------------

// File: rtl/unary_add_drv_4.sv
// unary_add_drv_4: sequencer for a 4-slot unary adder.
// One transaction streams two front-packed unary operands into the adder.
// It waits out the adder's carry latency, drains the unary result stream,
// counts the ones in that stream, and reports the count and the carry.
// Optional build macro: UNARY_DRV_CHECK_EN enables the result self-check
// that drives err.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start, adder disabled
// SEND   | 4 slots driving A/B unary operand bits (read phase)
// SETTLE | 2 slots with A=B=0 while the adder's carry propagates to C
// DRAIN  | 9 slots in write phase; din counted in W1..W8, W0 ignored
// DONE   | 1 slot reporting result/carry with a done pulse
//
// The output flops load from the next-state decode, so the output phase
// lines up with the state register. done is visible in the 16th cycle after
// the edge that accepts start.

module unary_add_drv_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opa,
    input  logic [2:0] opb,
    input  logic       din,
    input  logic       cin,
    output logic       A,
    output logic       B,
    output logic       en,
    output logic       read_or_write,
    output logic [2:0] result,
    output logic       carry,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, SEND, SETTLE, DRAIN, DONE} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [2:0] opa_q, opb_q, opa_nx, opb_nx;
    logic [1:0] slot_nx;
    logic       a_nx, b_nx, en_nx, rw_nx, busy_nx, done_nx;
    logic       carry_acc;
    logic [2:0] ones, ones_final;
    logic       fin;

    // Next-state, slot down-counter and next-output decode
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        opa_nx   = opa_q;
        opb_nx   = opb_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SEND;
                    cnt_nx   = 4'd3;
                    opa_nx   = (opa > 3'd4) ? 3'd4 : opa;
                    opb_nx   = (opb > 3'd4) ? 3'd4 : opb;
                end
            end
            SEND: begin
                if (cnt == 4'd0) begin
                    state_nx = SETTLE;
                    cnt_nx   = 4'd1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nx = DRAIN;
                    cnt_nx   = 4'd8;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DRAIN: begin
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // slot index k counts up while cnt counts down 3..0
        slot_nx = 2'(4'd3 - cnt_nx);
        a_nx    = (state_nx == SEND) && ({1'b0, slot_nx} < opa_nx);
        b_nx    = (state_nx == SEND) && ({1'b0, slot_nx} < opb_nx);
        en_nx   = (state_nx == SEND) || (state_nx == SETTLE) || (state_nx == DRAIN);
        rw_nx   = (state_nx == DRAIN);
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
    end

    // Last DRAIN edge (ending W8): the result is captured here
    assign fin        = (state == DRAIN) && (cnt == 4'd0);
    assign ones_final = (din && (ones != 3'd7)) ? ones + 3'd1 : ones;

    // State register, slot counter and latched operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            opa_q <= 3'd0;
            opb_q <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            opa_q <= opa_nx;
            opb_q <= opb_nx;
        end
    end

    // Registered adder-side and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A             <= 1'b0;
            B             <= 1'b0;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            A             <= a_nx;
            B             <= b_nx;
            en            <= en_nx;
            read_or_write <= rw_nx;
            busy          <= busy_nx;
            done          <= done_nx;
        end
    end

    // Sticky carry: cleared on accept, set by cin on any SEND/SETTLE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_acc <= 1'b0;
        end else if ((state == IDLE) && start) begin
            carry_acc <= 1'b0;
        end else if (((state == SEND) || (state == SETTLE)) && cin) begin
            carry_acc <= 1'b1;
        end
    end

    // Saturating ones counter over DRAIN W1..W8; W0 is skipped (cnt == 8)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones <= 3'd0;
        end else if ((state == SETTLE) && (cnt == 4'd0)) begin
            ones <= 3'd0;
        end else if ((state == DRAIN) && (cnt != 4'd8)) begin
            ones <= ones_final;
        end
    end

    // Result and carry capture, held until the next transaction completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 3'd0;
            carry  <= 1'b0;
        end else if (fin) begin
            result <= ones_final;
            carry  <= carry_acc;
        end
    end

`ifdef UNARY_DRV_CHECK_EN
    logic [3:0] op_sum;
    assign op_sum = {1'b0, opa_q} + {1'b0, opb_q};

    // Self-check of captured values against the clamped operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (fin) begin
            err <= (carry_acc != (op_sum >= 4'd5)) || (ones_final != op_sum[2:0]);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
